// File: rtl/video_shift_rx.sv
// video_shift_rx: receiving end of the HACK serial video link.
// Synchronises the asynchronous link wires (s_clk, s_data, s_reset) into the
// local clock domain and deserialises the MSB-first bit stream into screen
// words. Each completed word is emitted with its screen word address.
module video_shift_rx #(
    parameter  int WORD_W      = 16,
    parameter  int FRAME_WORDS = 8192,
    parameter  int SYNC_STAGES = 2,
    localparam int ADDR_W      = $clog2(FRAME_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_clk,
    input  logic              s_data,
    input  logic              s_reset,
    output logic [WORD_W-1:0] word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              word_valid,
    output logic              frame_done,
    output logic              sync_err,
    output logic              locked
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(WORD_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic {
        ST_UNLOCKED,
        ST_RECV
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   prev_clk;
    logic                   prev_srst;

    logic [WORD_W-1:0]      shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_W-1:0]      addr;

    logic lnk_clk, lnk_data, lnk_rst;
    logic rise, srst_rise, srst_fall;
    logic in_sync, do_shift, word_done, sync_err_d, lock_set;
    logic [CNT_W-1:0] bit_cnt_d;

    assign lnk_clk   = clk_sync[SYNC_STAGES-1];
    assign lnk_data  = data_sync[SYNC_STAGES-1];
    assign lnk_rst   = rst_sync[SYNC_STAGES-1];
    assign rise      = lnk_clk & ~prev_clk;
    assign srst_rise = lnk_rst & ~prev_srst;
    assign srst_fall = ~lnk_rst & prev_srst;

    // Input synchronisers plus the one-flop history used for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes a chain a chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '0;
            data_sync <= '0;
            rst_sync  <= '0;
            prev_clk  <= 1'b0;
            prev_srst <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], s_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], s_data};
            rst_sync  <= {rst_sync[SYNC_STAGES-2:0], s_reset};
            prev_clk  <= lnk_clk;
            prev_srst <= lnk_rst;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_UNLOCKED;
        else       state_q <= state_d;
    end

    // Next state and per-cycle datapath decode.
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        in_sync    = 1'b0;
        do_shift   = 1'b0;
        word_done  = 1'b0;
        sync_err_d = 1'b0;
        lock_set   = 1'b0;
        bit_cnt_d  = bit_cnt;
        case (state_q)
            ST_UNLOCKED: begin
                // Link bits are meaningless until the first frame sync.
                if (lnk_rst) state_d = ST_RECV;
            end
            ST_RECV: begin
                lock_set = srst_fall;
                if (lnk_rst) begin
                    // Sync wins over a coincident rise; a pending partial word
                    // is dropped and flagged.
                    in_sync    = 1'b1;
                    sync_err_d = srst_rise && (bit_cnt != '0);
                end else begin
                    word_done = (bit_cnt == FULL_CNT);
                    do_shift  = rise;
                    if (word_done) bit_cnt_d = '0;
                    if (do_shift)  bit_cnt_d = bit_cnt_d + 1'b1;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    // Shift register, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            addr       <= '0;
            word_data  <= '0;
            word_addr  <= '0;
            word_valid <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= sync_err_d;
            if (lock_set) locked <= 1'b1;
            if (in_sync) begin
                shreg   <= '0;
                bit_cnt <= '0;
                addr    <= '0;
            end else if (state_q == ST_RECV) begin
                if (word_done) begin
                    word_data  <= shreg;
                    word_addr  <= addr;
                    word_valid <= 1'b1;
                    frame_done <= (addr == LAST_ADDR);
                    addr       <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                end
                if (do_shift) shreg <= {shreg[WORD_W-2:0], lnk_data};
                bit_cnt <= bit_cnt_d;
            end
        end
    end

endmodule

// File: tb/tb_video_shift_rx.sv
// Testbench for video_shift_rx: drives the serial link with randomised phase
// lengths and compares received words against a bit-level reference model.
// A short frame length keeps the frame-wrap test inside a small cycle budget.
module tb_video_shift_rx;

    localparam int WORD_W      = 16;
    localparam int FRAME_WORDS = 32;
    localparam int ADDR_W      = $clog2(FRAME_WORDS);

    logic              clk = 1'b0;
    logic              reset;
    logic              s_clk, s_data, s_reset;
    logic [WORD_W-1:0] word_data;
    logic [ADDR_W-1:0] word_addr;
    logic              word_valid, frame_done, sync_err, locked;

    video_shift_rx #(
        .WORD_W(WORD_W),
        .FRAME_WORDS(FRAME_WORDS),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_clk(s_clk),
        .s_data(s_data),
        .s_reset(s_reset),
        .word_data(word_data),
        .word_addr(word_addr),
        .word_valid(word_valid),
        .frame_done(frame_done),
        .sync_err(sync_err),
        .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              fd;
    } word_t;

    int errors = 0;
    int checks = 0;

    // Observed traffic.
    word_t got_q[$];
    int    got_err   = 0;
    int    stray_fd  = 0;

    // Reference model state.
    word_t exp_q[$];
    bit    m_seen;
    bit    m_locked;
    int    m_cnt;
    int    m_word;
    int    m_addr;
    int    m_err;

    // Record every output pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (word_valid) got_q.push_back('{word_data, word_addr, frame_done});
        if (sync_err) got_err++;
        if (frame_done && !word_valid) stray_fd++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        m_seen = 0; m_locked = 0; m_cnt = 0; m_word = 0; m_addr = 0;
    endtask

    task automatic m_sync();
        if (m_seen && m_cnt != 0) m_err++;
        m_seen = 1; m_cnt = 0; m_word = 0; m_addr = 0;
    endtask

    task automatic m_bit(input bit b);
        if (!m_seen) return;
        m_word = ((m_word << 1) | int'(b)) & 32'hFFFF;
        m_cnt++;
        if (m_cnt == WORD_W) begin
            exp_q.push_back('{WORD_W'(m_word), ADDR_W'(m_addr), m_addr == FRAME_WORDS - 1});
            m_addr = (m_addr + 1) % FRAME_WORDS;
            m_cnt  = 0;
            m_word = 0;
        end
    endtask

    // One link bit: data changes with the falling s_clk, sampled on the rise.
    task automatic tx_bit(input bit b);
        s_clk  = 1'b0;
        s_data = b;
        wait_clks($urandom_range(4, 9));
        s_clk = 1'b1;
        m_bit(b);
        wait_clks($urandom_range(4, 9));
    endtask

    task automatic tx_word(input logic [WORD_W-1:0] w);
        for (int i = WORD_W - 1; i >= 0; i--) tx_bit(w[i]);
    endtask

    task automatic tx_sync();
        m_sync();
        s_reset = 1'b1;
        wait_clks(8);
        s_reset = 1'b0;
        m_locked = 1;
        wait_clks(8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic compare_words(input string tag);
        wait_clks(12);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
            check({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, "_fdone"}, got_q[i].fd, exp_q[i].fd);
        end
        check({tag, "_sync_err"}, got_err, m_err);
        check({tag, "_stray_fdone"}, stray_fd, 0);
        check({tag, "_locked"}, locked, m_locked);
        got_q.delete();
        exp_q.delete();
        got_err  = 0;
        stray_fd = 0;
        m_err    = 0;
    endtask

    initial begin
        reset = 1'b1; s_clk = 1'b0; s_data = 1'b0; s_reset = 1'b0;
        m_err = 0;
        m_reset();
        wait_clks(2);
        do_reset();

        // Reset state.
        check("rst_word_data", word_data, 0);
        check("rst_word_addr", word_addr, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_locked", locked, 0);

        // Bits before any sync are ignored.
        for (int i = 0; i < 20; i++) tx_bit(1'($urandom));
        compare_words("unlocked");

        // First sync and a fixed word, then another sync and 0x0001.
        tx_sync();
        tx_word(16'hA5C3);
        compare_words("first_word");
        tx_sync();
        tx_word(16'h0001);
        compare_words("word_0001");

        // Random words after a sync.
        tx_sync();
        for (int i = 0; i < 4; i++) tx_word(16'($urandom));
        compare_words("random_words");

        // Whole frame with data = address, then one more word past the wrap.
        tx_sync();
        for (int i = 0; i < FRAME_WORDS; i++) tx_word(16'(i));
        tx_word(16'hFFFF);
        compare_words("frame_wrap");

        // Sync with a partial word pending, then a clean word.
        tx_sync();
        for (int i = 0; i < 5; i++) tx_bit(1'($urandom));
        tx_sync();
        tx_word(16'h1234);
        compare_words("partial_sync");

        // Sync arriving with the rise of bit 16: the bit loses.
        tx_sync();
        for (int i = 0; i < 15; i++) tx_bit(1'($urandom));
        s_clk  = 1'b0;
        s_data = 1'($urandom);
        wait_clks(6);
        s_clk   = 1'b1;
        m_sync();
        s_reset = 1'b1;
        wait_clks(8);
        s_reset = 1'b0;
        wait_clks(8);
        compare_words("sync_vs_rise");

        // Reset mid-frame: outputs clear the next cycle, link ignored until sync.
        tx_sync();
        for (int i = 0; i < 3; i++) tx_word(16'($urandom));
        for (int i = 0; i < 7; i++) tx_bit(1'($urandom));
        wait_clks(12);
        got_q.delete();
        exp_q.delete();
        got_err = 0;
        m_err   = 0;
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        m_reset();
        check("midrst_word_data", word_data, 0);
        check("midrst_word_addr", word_addr, 0);
        check("midrst_word_valid", word_valid, 0);
        check("midrst_locked", locked, 0);
        for (int i = 0; i < 20; i++) tx_bit(1'($urandom));
        compare_words("after_reset");
        tx_sync();
        tx_word(16'($urandom));
        compare_words("resync");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
